// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the two write-back requesters and the register-file
// write port of wb_arbiter. The master modport is the requester/register-file
// side, the slave modport is the arbiter itself.
interface wb_arbiter_if #(
    parameter int addr_width = 5,
    parameter int data_width = 32
);
    logic                  a_valid;
    logic [addr_width-1:0] a_addr;
    logic [data_width-1:0] a_data;
    logic                  a_ready;
    logic                  b_valid;
    logic [addr_width-1:0] b_addr;
    logic [data_width-1:0] b_data;
    logic                  b_ready;
    logic [addr_width-1:0] wr_addr;
    logic [data_width-1:0] wr_data;
    logic                  wr_back_en;
    logic [7:0]            x0_drops;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  wr_addr, wr_data, wr_back_en, x0_drops
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output wr_addr, wr_data, wr_back_en, x0_drops
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-requester write-back arbiter (A = ALU, B = load unit) in
// front of a single register-file write port. Grants are combinational, the
// accepted write appears on the write port one cycle later. Writes to
// register 0 are accepted but discarded and counted in a saturating counter.
// Configuration macro WB_ARB_RR_EN: defined -> ties resolved round-robin
// against last_grant; undefined -> B always wins ties.
module wb_arbiter #(
    parameter int addr_width = 5,
    parameter int data_width = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_t;

    localparam logic LG_A = 1'b0;
    localparam logic LG_B = 1'b1;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_grant;
    logic [addr_width-1:0] r_wr_addr;
    logic [data_width-1:0] r_wr_data;
    logic [7:0]            r_x0_drops;

    logic                  w_tie_a_wins;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_xfer;
    logic [addr_width-1:0] w_xfer_addr;
    logic [data_width-1:0] w_xfer_data;
    logic                  w_xfer_x0;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

`ifdef WB_ARB_RR_EN
    // Round-robin: on a tie the requester that did not win last time goes.
    assign w_tie_a_wins = (r_last_grant == LG_B);
`else
    // Fixed priority: the load unit always wins a tie. last_grant is still
    // tracked so both builds keep the same state, it just never decides here.
    assign w_tie_a_wins = r_last_grant & 1'b0;
`endif

    // Grant selection; nobody is granted while reset is asserted.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (rst) begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
        end else if (bus.a_valid && bus.b_valid) begin
            if (w_tie_a_wins) begin
                w_grant_a = 1'b1;
            end else begin
                w_grant_b = 1'b1;
            end
        end else if (bus.a_valid) begin
            w_grant_a = 1'b1;
        end else if (bus.b_valid) begin
            w_grant_b = 1'b1;
        end else begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
        end
    end

    // Mux the granted requester's payload and classify the transfer.
    always_comb begin
        w_xfer      = w_grant_a | w_grant_b;
        w_xfer_addr = '0;
        w_xfer_data = '0;
        if (w_grant_a) begin
            w_xfer_addr = bus.a_addr;
            w_xfer_data = bus.a_data;
        end else if (w_grant_b) begin
            w_xfer_addr = bus.b_addr;
            w_xfer_data = bus.b_data;
        end else begin
            w_xfer_addr = '0;
            w_xfer_data = '0;
        end
        w_xfer_x0 = w_xfer && (w_xfer_addr == '0);
    end

    // Next state: which requester (if any) issued a real write this cycle.
    always_comb begin
        w_next_state = IDLE;
        case (1'b1)
            (w_grant_a && !w_xfer_x0): w_next_state = WR_A;
            (w_grant_b && !w_xfer_x0): w_next_state = WR_B;
            default:                   w_next_state = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write-port payload, arbitration pointer and register-0 drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_x0_drops   <= 8'd0;
            r_last_grant <= LG_B;
        end else begin
            if (w_xfer) begin
                r_last_grant <= w_grant_a ? LG_A : LG_B;
            end else begin
                r_last_grant <= r_last_grant;
            end
            if (w_xfer_x0) begin
                r_x0_drops <= sat_inc8(r_x0_drops);
            end else begin
                r_x0_drops <= r_x0_drops;
            end
            // Dropped and idle cycles leave the last real write on the port.
            if (w_xfer && !w_xfer_x0) begin
                r_wr_addr <= w_xfer_addr;
                r_wr_data <= w_xfer_data;
            end else begin
                r_wr_addr <= r_wr_addr;
                r_wr_data <= r_wr_data;
            end
        end
    end

    assign bus.a_ready    = w_grant_a;
    assign bus.b_ready    = w_grant_b;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.x0_drops   = r_x0_drops;
    assign bus.wr_back_en = (r_state != IDLE);
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter addr_width, default 5, register address width.
REQ-002 SHALL have parameter data_width, default 32, register data width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 a_valid  input  1  requester A (ALU) has a write-back pending.
REQ-007 a_addr  input  addr_width  requester A destination register.
REQ-008 a_data  input  data_width  requester A result.
REQ-009 a_ready  output  1  requester A accepted this cycle (combinational).
REQ-010 b_valid, b_addr, b_data, b_ready  SHALL mirror REQ-006..009 for requester B (load unit).
REQ-011 wr_addr  output  addr_width  register-file write address.
REQ-012 wr_data  output  data_width  register-file write data.
REQ-013 wr_back_en  output  1  register-file write enable.
REQ-014 x0_drops  output  8  saturating count of writes to register 0 discarded.

Function
REQ-015 A transfer SHALL occur on a requester when valid and ready are both high at a rising edge.
REQ-016 At most one of a_ready/b_ready SHALL be high in any cycle; ready SHALL never be high without its valid.
REQ-017 Only one requester valid -> that requester SHALL be granted the same cycle.
REQ-018 Both valid -> winner per arbitration policy (REQ-031/032); loser's ready SHALL be 0 and it must hold valid/addr/data stable.
REQ-019 Accepted transfer SHALL appear on wr_addr/wr_data with wr_back_en=1 exactly one cycle later (registered output, latency 1).
REQ-020 Cycle with no transfer -> wr_back_en SHALL be 0 next cycle; wr_addr/wr_data SHALL hold previous values.
REQ-021 Transfer with addr==0 SHALL be accepted (ready=1) but SHALL produce wr_back_en=0 next cycle and increment x0_drops.
REQ-022 x0_drops SHALL saturate at 255 and never wrap.
REQ-023 FSM states: IDLE (no write issued last cycle), WR_A (last issued write from A), WR_B (last issued write from B); state updates every cycle from the transfer taken.
REQ-024 Transitions: transfer from A with addr!=0 -> WR_A; from B with addr!=0 -> WR_B; no transfer or x0 drop -> IDLE.
REQ-025 wr_back_en SHALL equal (state != IDLE).
REQ-026 Arbitration pointer last_grant SHALL update only on a transfer (including x0 drops), to the granted requester.
REQ-027 Same addr from both in the same cycle SHALL still serialize: two writes on consecutive cycles, loser's write last.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, wr_back_en=0, wr_addr=0, wr_data=0, x0_drops=0, last_grant=B (so A wins first tie).
REQ-029 During reset cycles a_ready and b_ready SHALL be 0; no transfer occurs.
REQ-030 Reset asserted mid-stream SHALL discard any write issued in that cycle; the next-cycle wr_back_en SHALL be 0.

Configuration
REQ-031 Macro WB_ARB_RR_EN defined: ties resolved round-robin -- requester not equal to last_grant wins.
REQ-032 Macro WB_ARB_RR_EN undefined: fixed priority -- B (load) always wins ties; last_grant still maintained but unused.

Verification
REQ-033 Reset then a_valid=1,a_addr=5,a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle wr_back_en=1,wr_addr=5,wr_data=0x1234; state WR_A.
REQ-034 Both valid continuously (A addr 3 data 0xA, B addr 4 data 0xB), RR_EN defined -> grants A,B,A,B...; wr_addr sequence 3,4,3,4 one cycle delayed; never both ready.
REQ-035 Same stimulus, RR_EN undefined -> b_ready=1 every cycle, a_ready=0; wr_addr=4 every cycle after first.
REQ-036 300 consecutive A transfers with a_addr=0 -> wr_back_en stays 0; x0_drops reaches 255 and holds.
REQ-037 Transfer accepted, rst=1 next edge -> following cycle wr_back_en=0,wr_addr=0,x0_drops=0, state IDLE.
REQ-038 Both valid to addr 7 (A data 1, B data 2), RR_EN defined after reset -> writes 7/1 then 7/2 on consecutive cycles.
